// File: rtl/idli_sqi_mbuf_m.sv
// SQI slice buffer: a word-wide register file written one slice per push through a ping-pong or linear pointer.
// Latency: o_sqi_slice is combinational from buffer[ptr]; ptr, dir and wrd update on the edge that takes the push.
// Backpressure: none. Every push is accepted in the cycle it is presented, and clear or reset takes priority.
module idli_sqi_mbuf_m #(
   parameter int SLICE_W = 4,
   parameter int NSLICE  = 4,
   localparam int PTR_W  = $clog2(NSLICE),
   localparam int WORD_W = SLICE_W * NSLICE
) (
   input  logic               i_sqi_gck,
   input  logic               i_sqi_rst,
   input  logic [PTR_W-1:0]   i_sqi_ctr,
   input  logic               i_sqi_push,
   input  logic               i_sqi_mode,
   input  logic               i_sqi_clr,
   input  logic [SLICE_W-1:0] i_sqi_slice,
   output logic [SLICE_W-1:0] o_sqi_slice,
   output logic [WORD_W-1:0]  o_sqi_data,
   output logic               o_sqi_dir,
   output logic [PTR_W-1:0]   o_sqi_ptr,
   output logic               o_sqi_wrd
);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NSLICE - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // Buffer contents are deliberately not reset.
   logic [NSLICE-1:0][SLICE_W-1:0] buf_q;

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             dir_q, dir_d;
   logic             wrd_q, wrd_d;

   logic ctr_last;
   logic at_end;
   logic boundary;
   logic buf_we;

   assign ctr_last = &i_sqi_ctr;

   // End pointer: linear mode only ends at the top slice; ping-pong mode ends at whichever side it is heading to.
   always_comb begin
      at_end = 1'b0;
      if (i_sqi_mode) begin
         at_end = (ptr_q == PTR_LAST);
      end else if (dir_q) begin
         at_end = (ptr_q == '0);
      end else begin
         at_end = (ptr_q == PTR_LAST);
      end
   end

   assign boundary = i_sqi_push & ctr_last & at_end;

   // A write is suppressed whenever reset or clear claims the same edge.
   assign buf_we = i_sqi_push & ~i_sqi_clr & ~i_sqi_rst;

   // Pointer, direction and word-pulse next state. Clear wins over push, and an idle cycle holds position.
   always_comb begin
      ptr_d = ptr_q;
      dir_d = dir_q;
      wrd_d = 1'b0;
      if (i_sqi_clr) begin
         ptr_d = '0;
         dir_d = 1'b0;
      end else if (i_sqi_push) begin
         wrd_d = boundary;
         if (i_sqi_mode) begin
            ptr_d = ptr_q + PTR_ONE;
            dir_d = 1'b0;
         end else if (boundary) begin
            dir_d = ~dir_q;
         end else if (dir_q) begin
            ptr_d = ptr_q - PTR_ONE;
         end else begin
            ptr_d = ptr_q + PTR_ONE;
         end
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge i_sqi_gck) begin
      if (i_sqi_rst) begin
         ptr_q <= '0;
         dir_q <= 1'b0;
         wrd_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         dir_q <= dir_d;
         wrd_q <= wrd_d;
      end
   end

   // Slice write at the current pointer.
   always_ff @(posedge i_sqi_gck) begin
      if (buf_we) begin
         buf_q[ptr_q] <= i_sqi_slice;
      end
   end

   assign o_sqi_slice = buf_q[ptr_q];
   assign o_sqi_data  = buf_q;
   assign o_sqi_dir   = dir_q;
   assign o_sqi_ptr   = ptr_q;
   assign o_sqi_wrd   = wrd_q;

endmodule

// File: tb/tb_idli_sqi_mbuf_m.sv
// Bench for idli_sqi_mbuf_m: directed vectors, a reference model checked every cycle, and literal spot checks.
module tb_idli_sqi_mbuf_m;

   localparam int SW = 4;
   localparam int NS = 4;

   logic       clk;
   logic       rst;
   logic [1:0] ctr;
   logic       push;
   logic       mode;
   logic       clr;
   logic [3:0] sl_in;
   logic [3:0] sl_out;
   logic [15:0] data;
   logic       dir;
   logic [1:0] ptr;
   logic       wrd;

   int n_cmp  = 0;
   int n_fail = 0;

   idli_sqi_mbuf_m #(.SLICE_W(SW), .NSLICE(NS)) dut (
      .i_sqi_gck   (clk),
      .i_sqi_rst   (rst),
      .i_sqi_ctr   (ctr),
      .i_sqi_push  (push),
      .i_sqi_mode  (mode),
      .i_sqi_clr   (clr),
      .i_sqi_slice (sl_in),
      .o_sqi_slice (sl_out),
      .o_sqi_data  (data),
      .o_sqi_dir   (dir),
      .o_sqi_ptr   (ptr),
      .o_sqi_wrd   (wrd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: slice array with a validity mask, integer pointer and direction.
   int   m_buf [NS];
   bit   m_vld [NS];
   int   m_ptr = 0;
   int   m_dir = 0;
   int   m_wrd = 0;
   bit   m_known = 0;

   initial begin
      for (int k = 0; k < NS; k++) begin
         m_buf[k] = 0;
         m_vld[k] = 0;
      end
   end

   always @(posedge clk) begin
      bit last_slice;
      bit end_ptr;
      if (rst) begin
         m_ptr = 0; m_dir = 0; m_wrd = 0; m_known = 1;
      end else if (clr) begin
         m_ptr = 0; m_dir = 0; m_wrd = 0;
      end else if (push) begin
         last_slice = (int'(ctr) == NS - 1);
         if (mode)       end_ptr = (m_ptr == NS - 1);
         else if (m_dir) end_ptr = (m_ptr == 0);
         else            end_ptr = (m_ptr == NS - 1);
         m_buf[m_ptr] = int'(sl_in);
         m_vld[m_ptr] = 1;
         m_wrd = (last_slice && end_ptr) ? 1 : 0;
         if (mode) begin
            m_ptr = (m_ptr + 1) % NS;
            m_dir = 0;
         end else if (m_wrd == 1) begin
            m_dir = 1 - m_dir;
         end else if (m_dir == 1) begin
            m_ptr = (m_ptr + NS - 1) % NS;
         end else begin
            m_ptr = (m_ptr + 1) % NS;
         end
      end else begin
         m_wrd = 0;
      end
   end

   // Every-cycle comparison against the model, masking slices never written.
   always @(negedge clk) begin
      if (m_known) begin
         chk("ptr", 32'(ptr), 32'(m_ptr));
         chk("dir", 32'(dir), 32'(m_dir));
         chk("wrd", 32'(wrd), 32'(m_wrd));
         for (int k = 0; k < NS; k++) begin
            if (m_vld[k]) chk("data_slice", 32'(data[k*SW +: SW]), 32'(m_buf[k]));
         end
         if (m_vld[m_ptr]) chk("rd_slice", 32'(sl_out), 32'(m_buf[m_ptr]));
      end
   end

   // One stimulus cycle; pre returns o_sqi_slice as seen before the edge.
   task automatic cyc(input logic r, input logic c, input logic p, input logic md,
                      input logic [1:0] ct, input logic [3:0] s, output logic [3:0] pre);
      rst = r; clr = c; push = p; mode = md; ctr = ct; sl_in = s;
      #1;
      pre = sl_out;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      logic [3:0] dummy;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, dummy);
   endtask

   logic [3:0] pre;

   initial begin
      rst = 1'b1; clr = 1'b0; push = 1'b0; mode = 1'b0; ctr = '0; sl_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ptr", 32'(ptr), 32'd0);
      chk("rst_dir", 32'(dir), 32'd0);
      chk("rst_wrd", 32'(wrd), 32'd0);
      idle();

      // Mode 0 fill A,B,C,D
      cyc(0, 0, 1, 0, 2'd0, 4'hA, pre); chk("fill_ptr1", 32'(ptr), 32'd1);
      cyc(0, 0, 1, 0, 2'd1, 4'hB, pre); chk("fill_ptr2", 32'(ptr), 32'd2);
      cyc(0, 0, 1, 0, 2'd2, 4'hC, pre); chk("fill_ptr3", 32'(ptr), 32'd3);
      chk("fill_wrd_pre", 32'(wrd), 32'd0);
      cyc(0, 0, 1, 0, 2'd3, 4'hD, pre);
      chk("fill_ptr4", 32'(ptr), 32'd3);
      chk("fill_dir", 32'(dir), 32'd1);
      chk("fill_wrd", 32'(wrd), 32'd1);
      chk("fill_data", 32'(data), 32'hDCBA);
      idle();
      chk("fill_wrd_drop", 32'(wrd), 32'd0);

      // Mode 0 drain/refill E,F,0,1
      cyc(0, 0, 1, 0, 2'd0, 4'hE, pre); chk("drain_rd0", 32'(pre), 32'hD);
      cyc(0, 0, 1, 0, 2'd1, 4'hF, pre); chk("drain_rd1", 32'(pre), 32'hC);
      cyc(0, 0, 1, 0, 2'd2, 4'h0, pre); chk("drain_rd2", 32'(pre), 32'hB);
      cyc(0, 0, 1, 0, 2'd3, 4'h1, pre); chk("drain_rd3", 32'(pre), 32'hA);
      chk("drain_data", 32'(data), 32'hEF01);
      chk("drain_dir", 32'(dir), 32'd0);
      chk("drain_wrd", 32'(wrd), 32'd1);
      idle();

      // Mode 1 linear 1,2,3,4
      cyc(0, 0, 1, 1, 2'd0, 4'h1, pre);
      cyc(0, 0, 1, 1, 2'd1, 4'h2, pre);
      cyc(0, 0, 1, 1, 2'd2, 4'h3, pre);
      cyc(0, 0, 1, 1, 2'd3, 4'h4, pre);
      chk("lin_data", 32'(data), 32'h4321);
      chk("lin_ptr", 32'(ptr), 32'd0);
      chk("lin_dir", 32'(dir), 32'd0);
      chk("lin_wrd", 32'(wrd), 32'd1);
      chk("lin_slice", 32'(sl_out), 32'h1);
      idle();

      // Non-boundary wrap in mode 0
      cyc(0, 0, 1, 0, 2'd0, 4'h3, pre);
      cyc(0, 0, 1, 0, 2'd0, 4'h5, pre);
      cyc(0, 0, 1, 0, 2'd0, 4'h6, pre);
      chk("wrap_ptr_pre", 32'(ptr), 32'd3);
      cyc(0, 0, 1, 0, 2'd1, 4'h7, pre);
      chk("wrap_ptr", 32'(ptr), 32'd0);
      chk("wrap_dir", 32'(dir), 32'd0);
      chk("wrap_wrd", 32'(wrd), 32'd0);
      idle();

      // Clear overrides a simultaneous push
      cyc(0, 0, 1, 1, 2'd0, 4'h1, pre);
      cyc(0, 0, 1, 1, 2'd1, 4'h2, pre);
      cyc(0, 0, 1, 1, 2'd2, 4'h3, pre);
      cyc(0, 0, 1, 1, 2'd3, 4'h4, pre);
      cyc(0, 0, 1, 1, 2'd0, 4'h1, pre);
      cyc(0, 0, 1, 1, 2'd1, 4'h2, pre);
      chk("clr_ptr_pre", 32'(ptr), 32'd2);
      cyc(0, 1, 1, 1, 2'd2, 4'hF, pre);
      chk("clr_ptr", 32'(ptr), 32'd0);
      chk("clr_dir", 32'(dir), 32'd0);
      chk("clr_data", 32'(data), 32'h4321);
      chk("clr_wrd", 32'(wrd), 32'd0);
      idle();

      // Reset mid-operation with a simultaneous push
      cyc(0, 0, 1, 0, 2'd0, 4'h5, pre);
      cyc(0, 0, 1, 0, 2'd1, 4'h6, pre);
      cyc(0, 0, 1, 0, 2'd2, 4'h7, pre);
      cyc(0, 0, 1, 0, 2'd3, 4'h8, pre);
      cyc(0, 0, 1, 0, 2'd0, 4'h9, pre);
      chk("rstmid_ptr_pre", 32'(ptr), 32'd2);
      chk("rstmid_dir_pre", 32'(dir), 32'd1);
      chk("rstmid_data_pre", 32'(data), 32'h9765);
      cyc(1, 0, 1, 0, 2'd1, 4'hA, pre);
      chk("rstmid_ptr", 32'(ptr), 32'd0);
      chk("rstmid_dir", 32'(dir), 32'd0);
      chk("rstmid_wrd", 32'(wrd), 32'd0);
      chk("rstmid_data", 32'(data), 32'h9765);
      cyc(0, 0, 1, 0, 2'd0, 4'hB, pre);
      chk("rstmid_first", 32'(data), 32'h976B);
      chk("rstmid_ptr1", 32'(ptr), 32'd1);
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/idli_sqi_mbuf_m.md
IDLI_SQI_MBUF_M -- requirements
Module: idli_sqi_mbuf_m

Parameters
REQ-001 The block SHALL provide parameter SLICE_W, default 4, giving the width in bits of one SQI slice.
REQ-002 The block SHALL provide parameter NSLICE, default 4, giving slices per word; legal values are powers of two, at least 2.
REQ-003 The block SHALL derive PTR_W = clog2(NSLICE) and WORD_W = SLICE_W*NSLICE.

Interface
REQ-004 i_sqi_gck  in  1  clock; all state SHALL update on its rising edge.
REQ-005 i_sqi_rst  in  1  reset; it SHALL be synchronous and active-high.
REQ-006 i_sqi_ctr  in  PTR_W  global slice counter; all-ones marks the last slice of a word period.
REQ-007 i_sqi_push  in  1  writes i_sqi_slice into the buffer and advances the pointer.
REQ-008 i_sqi_mode  in  1  0 = reversing (ping-pong) mode, 1 = linear (ascending, wrapping) mode.
REQ-009 i_sqi_clr  in  1  realign: return pointer and direction to their initial state.
REQ-010 i_sqi_slice  in  SLICE_W  write data.
REQ-011 o_sqi_slice  out  SLICE_W  current buffer slice at the pointer.
REQ-012 o_sqi_data  out  WORD_W  whole buffer; slice k occupies bits [k*SLICE_W +: SLICE_W].
REQ-013 o_sqi_dir  out  1  current pointer direction (0 ascending, 1 descending).
REQ-014 o_sqi_ptr  out  PTR_W  current pointer.
REQ-015 o_sqi_wrd  out  1  one-cycle pulse marking word completion.

Function
REQ-016 On a push, buffer slice ptr SHALL take i_sqi_slice at the clock edge.
- o_sqi_slice SHALL show the pre-write value, combinationally from buffer[ptr].
REQ-017 A boundary push SHALL be a push with i_sqi_ctr all-ones and an end pointer, defined as:
- mode 0: (dir=0 and ptr=NSLICE-1) or (dir=1 and ptr=0);
- mode 1: ptr=NSLICE-1.
REQ-018 Mode 0 boundary push: ptr SHALL hold and dir SHALL toggle.
REQ-019 Mode 0 non-boundary push: ptr SHALL step by +1 if dir=0 or -1 if dir=1, modulo NSLICE.
- Wrap-around SHALL occur at an end pointer when ctr is not all-ones.
REQ-020 Mode 1 push: ptr SHALL step by +1 modulo NSLICE and dir SHALL become 0, regardless of its prior value.
REQ-021 With no push, ptr, dir and buffer contents SHALL hold.
REQ-022 o_sqi_wrd SHALL be 1 in the cycle after a boundary push, and 0 otherwise.
REQ-023 i_sqi_mode SHALL be sampled on every push; changing it between pushes is legal and takes effect on the next push.
REQ-024 i_sqi_clr SHALL set ptr=0, dir=0 and wrd=0 at the next edge.
- It SHALL override a simultaneous push: no buffer write, no pointer or direction step.
- It SHALL leave buffer contents unchanged.
REQ-025 Priority SHALL be: i_sqi_rst, then i_sqi_clr, then i_sqi_push.

Reset
REQ-026 While i_sqi_rst is high at an edge, ptr SHALL become 0, dir 0 and o_sqi_wrd 0.
- A simultaneous push SHALL be ignored, including its buffer write.
REQ-027 Buffer contents SHALL NOT be reset; o_sqi_data and o_sqi_slice are undefined until written, and checkers SHALL mask them.
REQ-028 Reset asserted mid-word SHALL discard the partial word position; the first push after reset writes slice 0.

Verification (SLICE_W=4, NSLICE=4)
REQ-029 Mode 0 fill: push A,B,C,D with ctr=0..3 -> ptr 0,1,2,3,3; dir=1 after the 4th push; o_sqi_data=0xDCBA; o_sqi_wrd=1 for exactly one cycle.
REQ-030 Mode 0 drain/refill, continuing from REQ-029: push E,F,0,1 with ctr=0..3 -> o_sqi_slice reads D,C,B,A before each write; o_sqi_data=0xEF01; dir returns to 0; wrd pulses.
REQ-031 Mode 1: push 1,2,3,4 with ctr=0..3 -> o_sqi_data=0x4321; ptr=0; dir=0; wrd pulses; o_sqi_slice=0x1.
REQ-032 Non-boundary wrap: mode 0, ptr=3, dir=0, push with ctr=1 -> ptr=0, dir=0, wrd stays 0.
REQ-033 Clear vs push: ptr=2, data=0x4321, clr and push of 0xF together -> ptr=0, dir=0, data stays 0x4321.
REQ-034 Reset mid-operation: ptr=2, dir=1, rst and push together -> next cycle ptr=0, dir=0, wrd=0; the following push writes slice 0.
